// File: rtl/spi_pkg.sv
// Shared defaults and state encoding for the Arduino SPI slave front end.
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise/fall strobes
// derived from the synced level against a one-cycle-delayed copy.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic FPGA_clk,
    input  logic FPGA_reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the pin's idle level so no spurious edge appears after reset.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 slave: assembles MSB-first words from the Arduino master and shifts tx_data
// out on MISO, all in the FPGA_clk domain.
module spi_slave_byte_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_reset,
    input  logic              arduino_sclk,
    input  logic              arduino_mosi,
    input  logic              arduino_ss_n,
    input  logic [DATA_W-1:0] tx_data,
    output logic              fpga_physical_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy,
    output spi_state_t        state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_n_s, ss_rise, ss_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic              miso_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .FPGA_clk   (FPGA_clk),
        .FPGA_reset (FPGA_reset),
        .async_in   (arduino_sclk),
        .level      (sclk_s),
        .rise       (sclk_rise),
        .fall       (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .FPGA_clk   (FPGA_clk),
        .FPGA_reset (FPGA_reset),
        .async_in   (arduino_ss_n),
        .level      (ss_n_s),
        .rise       (ss_rise),
        .fall       (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .FPGA_clk   (FPGA_clk),
        .FPGA_reset (FPGA_reset),
        .async_in   (arduino_mosi),
        .level      (mosi_s),
        .rise       (mosi_unused_rise),
        .fall       (mosi_unused_fall)
    );

    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q  <= 1'b0;
                    bit_cnt <= '0;
                    if (ss_fall) begin
                        tx_shift <= tx_data;
                        miso_q   <= tx_data[DATA_W-1];
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A completed word is delivered even if ss_n rises in the same cycle.
                    if (bit_cnt == CNT_W'(DATA_W)) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        tx_shift <= tx_data;
                        miso_q   <= tx_data[DATA_W-1];
                        if (ss_rise) begin
                            state  <= IDLE;
                            miso_q <= 1'b0;
                        end
                    end else if (ss_rise) begin
                        state   <= IDLE;
                        miso_q  <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            miso_q   <= tx_shift[DATA_W-2];
                        end else begin
                            // No shift on the fall after a word; refresh so a late tx_data write is still sent.
                            tx_shift <= tx_data;
                            miso_q   <= tx_data[DATA_W-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fpga_physical_miso = miso_q;
    assign busy               = ~ss_n_s;

endmodule

// File: tb/tb_spi_slave_byte_rx.sv
// Self-checking bench for spi_slave_byte_rx: SPI master driver at FPGA_clk/8, rx scoreboard.
module tb_spi_slave_byte_rx;
    import spi_pkg::*;

    logic       FPGA_clk;
    logic       FPGA_reset;
    logic       arduino_sclk;
    logic       arduino_mosi;
    logic       arduino_ss_n;
    logic [7:0] tx_data;
    logic       fpga_physical_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    spi_state_t state;

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    int exp_rx_cnt = 0;
    int exp_ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx;

    spi_slave_byte_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .FPGA_clk           (FPGA_clk),
        .FPGA_reset         (FPGA_reset),
        .arduino_sclk       (arduino_sclk),
        .arduino_mosi       (arduino_mosi),
        .arduino_ss_n       (arduino_ss_n),
        .tx_data            (tx_data),
        .fpga_physical_miso (fpga_physical_miso),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .frame_err          (frame_err),
        .busy               (busy),
        .state              (state)
    );

    // clock / watchdog
    initial begin
        FPGA_clk = 1'b0;
        forever #5 FPGA_clk = ~FPGA_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // scoreboard monitor, sampled 1 time unit after the active edge
    always begin
        @(posedge FPGA_clk);
        #1;
        if (!FPGA_reset) begin
            if (rx_valid || frame_err)
                check("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0)
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                else
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (frame_err) ferr_cnt++;
        end
    end

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge FPGA_clk);
    endtask

    task automatic spi_bits(input logic [7:0] mosi_b, input logic [7:0] miso_b, input int nbits);
        if (nbits == 8) begin
            exp_q.push_back(mosi_b);
            exp_rx_cnt++;
            last_rx = mosi_b;
        end
        for (int i = 0; i < nbits; i++) begin
            arduino_mosi = mosi_b[7-i];
            wait_clks(4);
            check("miso_bit", 32'(fpga_physical_miso), 32'(miso_b[7-i]));
            arduino_sclk = 1'b1;
            wait_clks(4);
            arduino_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] mosi_b, input logic [7:0] tx_b);
        tx_data = tx_b;
        arduino_ss_n = 1'b0;
        wait_clks(4);
        spi_bits(mosi_b, tx_b, 8);
        wait_clks(4);
        arduino_ss_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rx_cnt"}, 32'(rx_cnt), 32'(exp_rx_cnt));
        check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(exp_ferr_cnt));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(last_rx));
    endtask

    initial begin
        logic [7:0] r_mosi;
        logic [7:0] r_tx;
        FPGA_reset   = 1'b1;
        arduino_sclk = 1'b0;
        arduino_mosi = 1'b0;
        arduino_ss_n = 1'b1;
        tx_data      = 8'h00;
        last_rx      = 8'h00;
        wait_clks(3);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(fpga_physical_miso), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        FPGA_reset = 1'b0;
        wait_clks(4);

        // 1: single byte
        spi_frame(8'hA5, 8'h3C);
        check_counts("t1");
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: back-to-back bytes, tx_data updated after the first rx_valid
        tx_data = 8'h80;
        arduino_ss_n = 1'b0;
        wait_clks(4);
        check("t2_busy", 32'(busy), 32'd1);
        spi_bits(8'h01, 8'h80, 8);
        check("t2_first_rx_cnt", 32'(rx_cnt), 32'(exp_rx_cnt));
        tx_data = 8'h7E;
        spi_bits(8'hFF, 8'h7E, 8);
        wait_clks(4);
        arduino_ss_n = 1'b1;
        wait_clks(8);
        check_counts("t2");

        // 3: ss_n released after 5 rises, then a clean frame
        tx_data = 8'h55;
        arduino_ss_n = 1'b0;
        wait_clks(4);
        spi_bits(8'hE7, 8'h55, 5);
        wait_clks(4);
        arduino_ss_n = 1'b1;
        exp_ferr_cnt++;
        wait_clks(8);
        check_counts("t3_partial");
        spi_frame(8'h5A, 8'hC6);
        check_counts("t3");

        // 4: reset mid-frame
        tx_data = 8'h0F;
        arduino_ss_n = 1'b0;
        wait_clks(4);
        spi_bits(8'hF0, 8'h0F, 4);
        FPGA_reset = 1'b1;
        #1;
        check("t4_rx_data", 32'(rx_data), 32'd0);
        check("t4_rx_valid", 32'(rx_valid), 32'd0);
        check("t4_frame_err", 32'(frame_err), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_miso", 32'(fpga_physical_miso), 32'd0);
        check("t4_state", 32'(state), 32'(IDLE));
        last_rx = 8'h00;
        arduino_ss_n = 1'b1;
        wait_clks(2);
        FPGA_reset = 1'b0;
        wait_clks(8);
        spi_frame(8'hC3, 8'h96);
        check_counts("t4");

        // 5: SCLK activity with ss_n high
        for (int i = 0; i < 16; i++) begin
            arduino_mosi = 1'($urandom_range(0, 1));
            arduino_sclk = ~arduino_sclk;
            wait_clks(4);
            if (i % 4 == 3) begin
                check("t5_busy", 32'(busy), 32'd0);
                check("t5_miso", 32'(fpga_physical_miso), 32'd0);
            end
        end
        wait_clks(8);
        check_counts("t5");

        // 6: ss_n rises together with the 8th SCLK rise
        tx_data = 8'hA0;
        arduino_ss_n = 1'b0;
        wait_clks(4);
        spi_bits(8'hAB, 8'hA0, 7);
        arduino_mosi = 1'b1;
        wait_clks(4);
        arduino_sclk = 1'b1;
        arduino_ss_n = 1'b1;
        exp_ferr_cnt++;
        wait_clks(4);
        arduino_sclk = 1'b0;
        wait_clks(8);
        check_counts("t6_abort");
        spi_frame(8'h00, 8'hFF);
        spi_frame(8'hFF, 8'h00);
        check_counts("t6");

        // random frames
        for (int k = 0; k < 4; k++) begin
            r_mosi = 8'($urandom_range(0, 255));
            r_tx   = 8'($urandom_range(0, 255));
            spi_frame(r_mosi, r_tx);
        end
        check_counts("rand");

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) wait_clks(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
